// File: rtl/ledger_kv_store.sv
// ledger_kv_store: keyed balance ledger with a linear-scan lookup, debit/credit updates and a valid/ready handshake
module ledger_kv_store #(
  parameter int DEPTH = 8
) (
  input  logic                     tick_in,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               signal,
  input  logic [31:0]              key,
  input  logic                     transact_kind,
  input  logic [31:0]              transact_value,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [1:0]               resp_status,
  output logic [31:0]              resp_balance,
  output logic [$clog2(DEPTH):0]   entry_count
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] OK = 2'd0, REJ = 2'd1, FULL = 2'd2, NF = 2'd3;
  typedef enum logic [1:0] {IDLE, SEARCH, UPDATE, RESP} state_t;
  state_t state;
  logic [DEPTH-1:0] valid;
  logic [31:0] keys [DEPTH];
  logic [31:0] bals [DEPTH];
  logic [1:0] op;
  logic kind, hit, free, is_q, alloc, wr_en;
  logic [31:0] k, v, cur, bal;
  logic [32:0] sum;
  logic [IW-1:0] idx, hit_idx, free_idx, wr_idx;
  logic [1:0] st;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign cur = bals[hit_idx];
  assign sum = {1'b0, cur} + {1'b0, v};
  always_comb begin
    is_q = op == 2'd1;
    st = is_q ? (hit ? OK : NF)
       : !kind ? (!hit ? NF : (v > cur ? REJ : OK))
       : hit ? (sum[32] ? REJ : OK) : (free ? OK : FULL);
    bal = is_q ? (hit ? cur : 32'd0)
        : !kind ? (!hit ? 32'd0 : (v > cur ? cur : cur - v))
        : hit ? (sum[32] ? cur : sum[31:0]) : (free ? v : 32'd0);
    alloc = !is_q && kind && !hit && free;
    wr_en = !is_q && st == OK;
    wr_idx = hit ? hit_idx : free_idx;
  end
  always_ff @(posedge tick_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      valid <= '0;
      entry_count <= '0;
      resp_status <= OK;
      resp_balance <= '0;
      op <= '0;
      kind <= 1'b0;
      k <= '0;
      v <= '0;
      idx <= '0;
      hit <= 1'b0;
      free <= 1'b0;
      hit_idx <= '0;
      free_idx <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op <= signal;
          kind <= transact_kind;
          k <= key;
          v <= transact_value;
          idx <= '0;
          hit <= 1'b0;
          free <= 1'b0;
          hit_idx <= '0;
          free_idx <= '0;
          if (signal == 2'd1 || signal == 2'd2) state <= SEARCH;
          else begin
            resp_status <= OK;
            resp_balance <= '0;
            state <= RESP;
          end
        end
        SEARCH: begin
          if (valid[idx] && keys[idx] == k && !hit) begin
            hit <= 1'b1;
            hit_idx <= idx;
          end
          if (!valid[idx] && !free) begin
            free <= 1'b1;
            free_idx <= idx;
          end
          idx <= idx + 1'b1;
          if (idx == IW'(DEPTH - 1)) state <= UPDATE;
        end
        UPDATE: begin
          resp_status <= st;
          resp_balance <= bal;
          if (alloc) begin
            valid[free_idx] <= 1'b1;
            entry_count <= entry_count + 1'b1;
          end
          state <= RESP;
        end
        RESP: if (resp_ready) state <= IDLE;
      endcase
    end
  end
  // Table payload needs no reset: valid bits alone define membership
  always_ff @(posedge tick_in) begin
    if (state == UPDATE && wr_en) begin
      keys[wr_idx] <= k;
      bals[wr_idx] <= bal;
    end
  end
endmodule

// File: tb/tb_ledger_kv_store.sv
// tb_ledger_kv_store: directed checks of ledger_kv_store with hand-computed expectations
module tb_ledger_kv_store;
  localparam int DEPTH = 8;
  logic tick_in = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] signal = '0;
  logic [31:0] key = '0;
  logic transact_kind = 1'b0;
  logic [31:0] transact_value = '0;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic [1:0] resp_status;
  logic [31:0] resp_balance;
  logic [$clog2(DEPTH):0] entry_count;
  int checks = 0;
  int failures = 0;

  ledger_kv_store #(.DEPTH(DEPTH)) dut (
    .tick_in(tick_in), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .signal(signal), .key(key), .transact_kind(transact_kind), .transact_value(transact_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .resp_balance(resp_balance), .entry_count(entry_count)
  );

  always #5 tick_in = ~tick_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge tick_in);
    @(negedge tick_in);
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] kk, input logic kd, input logic [31:0] vv);
    @(negedge tick_in);
    signal = s;
    key = kk;
    transact_kind = kd;
    transact_value = vv;
    req_valid = 1'b1;
    resp_ready = 1'b0;
    @(posedge tick_in);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int lat);
    int n;
    n = 1;
    while (!resp_valid && n < 100) begin
      @(posedge tick_in);
      #1 n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
  endtask

  task automatic op(input string tag, input logic [1:0] s, input logic [31:0] kk, input logic kd,
                    input logic [31:0] vv, input logic [1:0] es, input logic [31:0] eb);
    send(s, kk, kd, vv);
    wait_resp(tag, (s == 2'd1 || s == 2'd2) ? DEPTH + 2 : 1);
    chk({tag, "_status"}, 64'(resp_status), 64'(es));
    chk({tag, "_balance"}, 64'(resp_balance), 64'(eb));
    resp_ready = 1'b1;
    @(posedge tick_in);
    #1 resp_ready = 1'b0;
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    do_reset();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_status", 64'(resp_status), 64'd0);
    chk("rst_balance", 64'(resp_balance), 64'd0);
    chk("rst_count", 64'(entry_count), 64'd0);

    op("noop0", 2'd0, 32'd5, 1'b1, 32'd9, 2'd0, 32'd0);
    op("noop3", 2'd3, 32'd5, 1'b1, 32'd9, 2'd0, 32'd0);
    op("q_absent0", 2'd1, 32'd0, 1'b0, 32'd0, 2'd3, 32'd0);
    op("cr5_100", 2'd2, 32'd5, 1'b1, 32'd100, 2'd0, 32'd100);
    chk("cnt_after_cr5", 64'(entry_count), 64'd1);
    op("db5_30", 2'd2, 32'd5, 1'b0, 32'd30, 2'd0, 32'd70);
    op("q5_70", 2'd1, 32'd5, 1'b0, 32'd0, 2'd0, 32'd70);

    send(2'd2, 32'd5, 1'b0, 32'd71);
    wait_resp("db5_71", DEPTH + 2);
    req_valid = 1'b1;
    signal = 2'd2;
    key = 32'd77;
    transact_kind = 1'b1;
    transact_value = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge tick_in);
      #1;
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_status", 64'(resp_status), 64'd1);
      chk("stall_balance", 64'(resp_balance), 64'd70);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge tick_in);
    #1 resp_ready = 1'b0;
    chk("stall_release", 64'(resp_valid), 64'd0);
    chk("stall_count", 64'(entry_count), 64'd1);
    op("q77_ignored", 2'd1, 32'd77, 1'b0, 32'd0, 2'd3, 32'd0);

    op("cr5_ovf", 2'd2, 32'd5, 1'b1, 32'hFFFF_FFC0, 2'd1, 32'd70);
    op("db9_absent", 2'd2, 32'd9, 1'b0, 32'd1, 2'd3, 32'd0);
    chk("cnt_after_db9", 64'(entry_count), 64'd1);
    op("cr0_zero", 2'd2, 32'd0, 1'b1, 32'd0, 2'd0, 32'd0);
    chk("cnt_after_cr0", 64'(entry_count), 64'd2);
    op("q0_zero", 2'd1, 32'd0, 1'b0, 32'd0, 2'd0, 32'd0);
    op("cr5_to_max", 2'd2, 32'd5, 1'b1, 32'hFFFF_FFB9, 2'd0, 32'hFFFF_FFFF);
    op("db5_all", 2'd2, 32'd5, 1'b0, 32'hFFFF_FFFF, 2'd0, 32'd0);
    op("q5_after_all", 2'd1, 32'd5, 1'b0, 32'd0, 2'd0, 32'd0);

    send(2'd2, 32'd3, 1'b1, 32'd9);
    repeat (3) @(posedge tick_in);
    #2 reset_n = 1'b0;
    #2;
    chk("midrst_count", 64'(entry_count), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    @(negedge tick_in);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      @(posedge tick_in);
      #1 if (resp_valid) seen = 1'b1;
    end
    chk("midrst_no_resp", 64'(seen), 64'd0);
    chk("midrst_count_after", 64'(entry_count), 64'd0);
    op("q3_after_rst", 2'd1, 32'd3, 1'b0, 32'd0, 2'd3, 32'd0);
    op("q5_after_rst", 2'd1, 32'd5, 1'b0, 32'd0, 2'd3, 32'd0);

    for (int i = 0; i < DEPTH; i++) op($sformatf("fill%0d", i), 2'd2, 32'(i), 1'b1, 32'd1, 2'd0, 32'd1);
    chk("cnt_full", 64'(entry_count), 64'd8);
    op("cr8_full", 2'd2, 32'd8, 1'b1, 32'd1, 2'd2, 32'd0);
    chk("cnt_still_full", 64'(entry_count), 64'd8);
    op("cr3_when_full", 2'd2, 32'd3, 1'b1, 32'd5, 2'd0, 32'd6);
    op("q8_absent", 2'd1, 32'd8, 1'b0, 32'd0, 2'd3, 32'd0);
    op("q7_present", 2'd1, 32'd7, 1'b0, 32'd0, 2'd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ledger_kv_store.md
LEDGER_KV_STORE -- requirements
Module: ledger_kv_store

Interface
REQ-001 Parameter: DEPTH, 8, number of ledger entries (2..64).
REQ-002 Port: tick_in  input  1  clock; all state updates on the rising edge.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: req_valid  input  1  request present on signal/key/transact_kind/transact_value.
REQ-005 Port: req_ready  output  1  block can accept a request.
REQ-006 Port: signal  input  2  opcode: 1 = query, 2 = transaction, 0/3 = no-op.
REQ-007 Port: key  input  32  account key; every value is legal, including 0.
REQ-008 Port: transact_kind  input  1  0 = debit, 1 = credit; ignored for query.
REQ-009 Port: transact_value  input  32  unsigned amount.
REQ-010 Port: resp_valid  output  1  response present.
REQ-011 Port: resp_ready  input  1  consumer accepts the response.
REQ-012 Port: resp_status  output  2  0 OK, 1 REJECTED, 2 FULL, 3 NOT_FOUND.
REQ-013 Port: resp_balance  output  32  balance of the key after the operation, or 0 if the key is absent.
REQ-014 Port: entry_count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 The block SHALL hold DEPTH entries, each with a valid bit, a 32-bit key and a 32-bit unsigned balance.
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; all request fields are captured on that edge.
REQ-017 The FSM SHALL use the states IDLE, SEARCH, UPDATE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 An accepted no-op SHALL return IDLE -> RESP directly, with status OK and balance 0.
REQ-019 IDLE SHALL move to SEARCH on acceptance of a query or transaction.
REQ-020 SEARCH SHALL examine one entry per cycle, indices 0 to DEPTH-1, always for exactly DEPTH cycles.
REQ-021 SEARCH SHALL record the first valid matching index and the lowest invalid index; it then moves to UPDATE.
REQ-022 UPDATE SHALL perform at most one table write and form the response; it then moves to RESP.
REQ-023 A query on a found key SHALL return OK with its balance; on an absent key it SHALL return NOT_FOUND with balance 0.
REQ-024 A debit on a found key SHALL return OK with the new balance when value <= balance, and subtract value from the balance.
REQ-025 A debit with value > balance SHALL return REJECTED with the balance unchanged.
REQ-026 A debit on an absent key SHALL return NOT_FOUND and SHALL NOT allocate an entry.
REQ-027 A credit on a found key SHALL add value when the 33-bit sum <= 32'hFFFFFFFF; on overflow it SHALL return REJECTED with the balance unchanged.
REQ-028 A credit on an absent key SHALL allocate the lowest free slot with balance = value and return OK.
REQ-029 A credit on an absent key with no free slot SHALL return FULL with balance 0 and leave the table unchanged.
REQ-030 A transaction with value 0 SHALL be legal; a credit of 0 to an absent key SHALL still allocate.
REQ-031 In RESP, resp_valid = 1 and resp_status/resp_balance SHALL be held stable until resp_ready = 1.
REQ-032 RESP SHALL return to IDLE on the edge where resp_ready = 1.
REQ-033 Latency SHALL be DEPTH+2 cycles from the acceptance edge to resp_valid for a query or transaction, and 1 cycle for a no-op.
REQ-034 Throughput SHALL be one request in flight; req_valid while busy SHALL be ignored, and the upstream holds it.
REQ-035 entry_count SHALL increment on the UPDATE edge of an allocation; entries are never freed, and a zero balance remains a valid entry.

Reset
REQ-036 When reset_n = 0, the block SHALL immediately clear all valid bits and set the FSM to IDLE.
REQ-037 Reset SHALL drive req_ready = 1 after release, and resp_valid = 0, resp_status = 0, resp_balance = 0 and entry_count = 0.
REQ-038 Reset asserted mid-SEARCH, UPDATE or RESP SHALL discard the request with no table write and no response.

Verification
REQ-039 Credit key 5 value 100 to an empty table -> OK, balance 100, entry_count 1, resp_valid 10 cycles after accept (DEPTH 8).
REQ-040 Debit key 5 value 30, then query key 5 -> OK 70, then OK 70; debit 71 -> REJECTED 70.
REQ-041 Credit key 5 value 32'hFFFFFFC0 at balance 70 -> REJECTED 70; debit key 9 value 1 -> NOT_FOUND 0, entry_count unchanged.
REQ-042 Credit keys 0..7 value 1 each, then credit key 8 value 1 -> keys 0..7 OK, key 8 FULL 0, entry_count 8.
REQ-043 Hold resp_ready = 0 for 5 cycles -> resp_valid and data stay stable, req_ready stays 0, and a new req_valid is not accepted.
REQ-044 Pulse reset_n low during SEARCH of a credit to key 3 -> no response, entry_count 0, and a later query of key 3 -> NOT_FOUND.
